// File: rtl/emulib_rammodel_pkg.sv
// Shared definitions for the RAM model response decoders: response word layout and AXI BRESP codes.
package emulib_rammodel_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BID_LSB   = 16;
  localparam int unsigned BID_W     = 16;
  localparam int unsigned REP_LSB   = 8;
  localparam int unsigned REP_W     = 8;
  localparam int unsigned RSVD_W    = 6;
  localparam int unsigned BRESP_LSB = 0;
  localparam int unsigned BRESP_W   = 2;

  typedef enum logic [BRESP_W-1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } bresp_e;

  // B response word as it arrives from the timing/back-end stream
  typedef struct packed {
    logic [BID_W-1:0]   bid;
    logic [REP_W-1:0]   rep;
    logic [RSVD_W-1:0]  rsvd;
    logic [BRESP_W-1:0] bresp;
  } b_word_t;

endpackage

// File: rtl/emulib_rammodel_sync_fifo.sv
// Single-clock circular FIFO with wrap-bit pointers; registered occupancy count, combinational head read.
module emulib_rammodel_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Same index with differing wrap bits means every slot is occupied
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage carries no reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/emulib_rammodel_decoder_b_queued.sv
// Queued B-channel decoder: buffers response words and expands each into rep+1 AXI B beats.
module emulib_rammodel_decoder_b_queued
  import emulib_rammodel_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic [WORD_W-1:0]        data,
  output logic                     axi_bvalid,
  input  logic                     axi_bready,
  output logic [ID_WIDTH-1:0]      axi_bid,
  output logic [BRESP_W-1:0]       axi_bresp,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     idle
);

  localparam int unsigned ENTRY_W = ID_WIDTH + REP_W + BRESP_W;

  if (ID_WIDTH < 1 || ID_WIDTH > BID_W || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      ADDR_WIDTH == 0 || DATA_WIDTH == 0) begin : g_bad_cfg
    $error("emulib_rammodel_decoder_b_queued: unsupported parameter set");
  end

  typedef enum logic {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  b_word_t              word;
  logic                 unused_word;
  logic [ENTRY_W-1:0]   push_entry;
  logic [ENTRY_W-1:0]   head_entry;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  logic [ID_WIDTH-1:0]  head_bid;
  logic [REP_W-1:0]     head_rep;
  logic [BRESP_W-1:0]   head_bresp;

  state_e               state_q,  state_d;
  logic [ID_WIDTH-1:0]  bid_q,    bid_d;
  logic [BRESP_W-1:0]   bresp_q,  bresp_d;
  logic [REP_W-1:0]     cnt_q,    cnt_d;
  logic                 bfire;

  // Decode: truncate bid to ID_WIDTH, drop reserved bits
  assign word        = b_word_t'(data);
  assign unused_word = ^{word.bid, word.rsvd};
  assign push_entry  = {word.bid[ID_WIDTH-1:0], word.rep, word.bresp};

  assign fifo_push  = data_valid && !fifo_full;
  assign data_ready = !fifo_full;

  emulib_rammodel_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_bid   = head_entry[ENTRY_W-1 -: ID_WIDTH];
  assign head_rep   = head_entry[BRESP_W +: REP_W];
  assign head_bresp = head_entry[BRESP_W-1:0];

  assign axi_bvalid = (state_q == ACTIVE);
  assign axi_bid    = bid_q;
  assign axi_bresp  = bresp_q;
  assign bfire      = axi_bvalid && axi_bready;
  assign pending    = fifo_count;
  assign idle       = fifo_empty && (state_q == EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      bid_q   <= '0;
      bresp_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bid_q   <= bid_d;
      bresp_q <= bresp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output stage: load from queue head, repeat the beat cnt+1 times, reload without a bubble
  always_comb begin
    state_d  = state_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          bid_d    = head_bid;
          bresp_d  = head_bresp;
          cnt_d    = head_rep;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bfire) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - REP_W'(1);
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            bid_d    = head_bid;
            bresp_d  = head_bresp;
            cnt_d    = head_rep;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_emulib_rammodel_decoder_b_queued.sv
// Bench for the queued B decoder: queue-level reference model checked every cycle plus directed literal checks.
module tb_emulib_rammodel_decoder_b_queued;
  import emulib_rammodel_pkg::*;

  localparam int ID_W = 4;
  localparam int DEP  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              data_valid;
  logic              data_ready;
  logic [31:0]       data;
  logic              axi_bvalid;
  logic              axi_bready;
  logic [ID_W-1:0]   axi_bid;
  logic [1:0]        axi_bresp;
  logic [2:0]        pending;
  logic              idle;

  int checks   = 0;
  int failures = 0;

  emulib_rammodel_decoder_b_queued #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (64),
    .ID_WIDTH   (ID_W),
    .DEPTH      (DEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data       (data),
    .axi_bvalid (axi_bvalid),
    .axi_bready (axi_bready),
    .axi_bid    (axi_bid),
    .axi_bresp  (axi_bresp),
    .pending    (pending),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words waiting in the queue, and the word currently being replayed
  typedef struct {int bid; int rep; int bresp;} word_t;
  word_t m_q[$];
  bit    m_sv;
  int    m_bid, m_bresp, m_left;
  bit    started;
  bit    m_acc;
  word_t m_nw;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_sv    = 1'b0;
      started = 1'b1;
    end else if (started) begin
      m_acc    = data_valid && (m_q.size() < DEP);
      m_nw.bid   = int'((data >> 16) & ((32'd1 << ID_W) - 1));
      m_nw.rep   = int'((data >> 8) & 32'hFF);
      m_nw.bresp = int'(data & 32'h3);
      if (m_sv && axi_bready) begin
        if (m_left > 0) m_left--;
        else m_sv = 1'b0;
      end
      if (!m_sv && m_q.size() > 0) begin
        m_bid   = m_q[0].bid;
        m_bresp = m_q[0].bresp;
        m_left  = m_q[0].rep;
        m_sv    = 1'b1;
        void'(m_q.pop_front());
      end
      if (m_acc) m_q.push_back(m_nw);
    end
  end

  // Per-cycle comparison against the model, and capture of beats that will fire on the next edge
  word_t cap[$];
  word_t cw;
  always @(negedge clk) begin
    if (started) begin
      chk("cyc_ready",   32'(data_ready), 32'(m_q.size() < DEP));
      chk("cyc_pending", 32'(pending),    32'(m_q.size()));
      chk("cyc_bvalid",  32'(axi_bvalid), 32'(m_sv));
      chk("cyc_idle",    32'(idle),       32'(m_q.size() == 0 && !m_sv));
      if (m_sv) begin
        chk("cyc_bid",   32'(axi_bid),   32'(m_bid));
        chk("cyc_bresp", 32'(axi_bresp), 32'(m_bresp));
      end
    end
    if (axi_bvalid === 1'b1 && axi_bready && !rst) begin
      cw.bid   = int'(axi_bid);
      cw.bresp = int'(axi_bresp);
      cw.rep   = 0;
      cap.push_back(cw);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    bit ok;
    bit rdy;
    ok = 1'b0;
    data = w;
    data_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      rdy = data_ready;
      step();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    data_valid = 1'b0;
    if (!ok) chk("push_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (idle) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) chk("idle_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int errs;

  initial begin
    rst = 1'b1;
    data_valid = 1'b0;
    data = '0;
    axi_bready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_bvalid",  32'(axi_bvalid), 32'(0));
    chk("rst_ready",   32'(data_ready), 32'(1));
    chk("rst_pending", 32'(pending),    32'(0));
    chk("rst_idle",    32'(idle),       32'(1));

    // Single word: two-cycle latency, one beat
    cap.delete();
    push_word(32'h0005_0000);
    chk("t1_pending",  32'(pending),    32'(1));
    chk("t1_bvalid0",  32'(axi_bvalid), 32'(0));
    step();
    chk("t1_bvalid1",  32'(axi_bvalid), 32'(1));
    chk("t1_bid",      32'(axi_bid),    32'(5));
    chk("t1_bresp",    32'(axi_bresp),  32'(OKAY));
    step();
    chk("t1_done",     32'(axi_bvalid), 32'(0));
    chk("t1_idle",     32'(idle),       32'(1));
    chk("t1_beats",    32'(cap.size()), 32'(1));

    // Repeat: rep=3, SLVERR -> four back-to-back beats
    cap.delete();
    push_word(32'h0003_0302);
    step();
    for (int b = 0; b < 4; b++) begin
      chk("t2_bvalid",  32'(axi_bvalid), 32'(1));
      chk("t2_bid",     32'(axi_bid),    32'(3));
      chk("t2_bresp",   32'(axi_bresp),  32'(SLVERR));
      chk("t2_pending", 32'(pending),    32'(0));
      step();
    end
    chk("t2_end",   32'(axi_bvalid), 32'(0));
    chk("t2_beats", 32'(cap.size()), 32'(4));

    // Backpressure until full, then release: push blocked at full even while popping
    axi_bready = 1'b0;
    cap.delete();
    for (int i = 1; i <= 5; i++) push_word({16'(i), 16'h0000});
    chk("t3_pending", 32'(pending),    32'(4));
    chk("t3_ready",   32'(data_ready), 32'(0));
    chk("t3_bvalid",  32'(axi_bvalid), 32'(1));
    chk("t3_bid",     32'(axi_bid),    32'(1));
    data = 32'h0006_0000;
    data_valid = 1'b1;
    repeat (3) step();
    chk("t3_hold_bv",  32'(axi_bvalid), 32'(1));
    chk("t3_hold_bid", 32'(axi_bid),    32'(1));
    chk("t3_stall",    32'(data_ready), 32'(0));
    axi_bready = 1'b1;
    step();
    chk("t4_no_pass",  32'(pending),    32'(3));
    chk("t4_ready",    32'(data_ready), 32'(1));
    chk("t4_bid",      32'(axi_bid),    32'(2));
    step();
    data_valid = 1'b0;
    chk("t4_pushpop",  32'(pending),    32'(3));
    wait_idle(50);
    chk("t3_beats", 32'(cap.size()), 32'(6));
    errs = 0;
    for (int i = 0; i < cap.size(); i++) if (cap[i].bid != i + 1) errs++;
    chk("t3_order", 32'(errs), 32'(0));

    // Truncation and 256-beat repeat
    cap.delete();
    push_word(32'hABCD_FF00);
    wait_idle(400);
    chk("t5_beats", 32'(cap.size()), 32'(256));
    errs = 0;
    foreach (cap[i]) if (cap[i].bid != 32'hD || cap[i].bresp != 0) errs++;
    chk("t5_trunc", 32'(errs), 32'(0));

    // Pointer wrap over 12 words with mixed bresp
    cap.delete();
    for (int i = 0; i < 12; i++) push_word({16'(i + 16), 14'h0, 2'(i)});
    wait_idle(50);
    chk("t5_wrap_n", 32'(cap.size()), 32'(12));
    errs = 0;
    foreach (cap[i]) if (cap[i].bid != (i % 16) || cap[i].bresp != (i % 4)) errs++;
    chk("t5_wrap_order", 32'(errs), 32'(0));

    // Reset during the second beat of a rep=5 burst
    cap.delete();
    push_word(32'h0009_0501);
    step();
    chk("t6_beat1", 32'(axi_bid), 32'(9));
    step();
    chk("t6_beat2", 32'(axi_bvalid), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_bvalid",  32'(axi_bvalid), 32'(0));
    chk("t6_pending", 32'(pending),    32'(0));
    chk("t6_idle",    32'(idle),       32'(1));
    chk("t6_ready",   32'(data_ready), 32'(1));
    repeat (10) step();
    chk("t6_beats",   32'(cap.size()), 32'(1));
    chk("t6_quiet",   32'(axi_bvalid), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
